// File: rtl/writeback_stage_pkg.sv
// Shared pipeline definitions for the writeback stage: MD select encodings,
// FSM state encoding and the default memory-wait budget.
package writeback_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEM_REQ = 2'd1,
      ST_WB      = 2'd2
   } wb_state_t;

   localparam logic [1:0] MD_RESULT = 2'd0;
   localparam logic [1:0] MD_MEM    = 2'd1;
   localparam logic [1:0] MD_SLT    = 2'd2;
   localparam logic [1:0] MD_RSVD   = 2'd3;

   localparam int MEM_TIMEOUT_DEF = 15;
   localparam int WAIT_CNT_BITS   = 4;

   // The reserved MD code behaves exactly like the ALU-result select.
   function automatic logic [1:0] md_mux_sel(input logic [1:0] md);
      return (md == MD_RSVD) ? MD_RESULT : md;
   endfunction

endpackage

// File: rtl/writeback_stage_mux.sv
// Three-input data select used for the writeback data path; select code 3
// falls back to input 0.
module three_to_one_mux #(
   parameter int WIDTH = 32
) (
   input  logic [1:0]       i_sel,
   input  logic [WIDTH-1:0] i_in0,
   input  logic [WIDTH-1:0] i_in1,
   input  logic [WIDTH-1:0] i_in2,
   output logic [WIDTH-1:0] o_out
);

   always_comb begin
      o_out = i_in0;
      case (i_sel)
         2'd1:    o_out = i_in1;
         2'd2:    o_out = i_in2;
         default: o_out = i_in0;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU ops in one cycle, runs loads/stores through a
// req/ack memory port with a bounded wait, and drives the register-file write.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int DATA_BITS      = 32,
   parameter int reg_addr_width = 5,
   parameter int MEM_TIMEOUT    = MEM_TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      valid_in,
   input  logic                      RW,
   input  logic [reg_addr_width-1:0] DA,
   input  logic [1:0]                MD,
   input  logic                      MW,
   input  logic [DATA_BITS-1:0]      result,
   input  logic                      determinate,
   input  logic [DATA_BITS-1:0]      DData,
   output logic                      stall,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [DATA_BITS-1:0]      mem_addr,
   output logic [DATA_BITS-1:0]      mem_wdata,
   input  logic                      mem_ack,
   input  logic [DATA_BITS-1:0]      mem_rdata,
   output logic                      reg_we,
   output logic [reg_addr_width-1:0] reg_addr,
   output logic [DATA_BITS-1:0]      reg_wdata,
   output logic                      mem_err,
   output logic [1:0]                o_dbg_state
);

   localparam logic [WAIT_CNT_BITS-1:0] LP_LAST_WAIT = WAIT_CNT_BITS'(MEM_TIMEOUT - 1);

   wb_state_t                 r_state;
   wb_state_t                 w_next_state;
   logic [WAIT_CNT_BITS-1:0]  r_wait_cnt;
   logic                      r_mem_we;
   logic [DATA_BITS-1:0]      r_mem_addr;
   logic [DATA_BITS-1:0]      r_mem_wdata;
   logic                      r_rw;
   logic [reg_addr_width-1:0] r_da;
   logic                      r_reg_we;
   logic [reg_addr_width-1:0] r_reg_addr;
   logic [DATA_BITS-1:0]      r_reg_wdata;
   logic                      r_mem_err;

   logic                      w_accept;
   logic                      w_is_mem;
   logic                      w_mem_accept;
   logic                      w_alu_accept;
   logic                      w_ack;
   logic                      w_timeout;
   logic [1:0]                w_sel;
   logic [DATA_BITS-1:0]      w_slt_data;
   logic [DATA_BITS-1:0]      w_mux_out;

   // Handshake: an op is taken when valid_in=1 in IDLE; while stall=1 the
   // upstream holds its outputs and nothing presented is consumed.
   assign w_accept     = (r_state == ST_IDLE) && valid_in;
   assign w_is_mem     = MW || (MD == MD_MEM);
   assign w_mem_accept = w_accept && w_is_mem;
   assign w_alu_accept = w_accept && !w_is_mem;
   assign w_ack        = (r_state == ST_MEM_REQ) && mem_ack;
   assign w_timeout    = (r_state == ST_MEM_REQ) && !mem_ack && (r_wait_cnt == LP_LAST_WAIT);

   // Outside IDLE the only data source is the load return.
   assign w_sel      = (r_state == ST_IDLE) ? md_mux_sel(MD) : MD_MEM;
   assign w_slt_data = {{(DATA_BITS-1){1'b0}}, determinate};

   three_to_one_mux #(
      .WIDTH (DATA_BITS)
   ) u_md_mux (
      .i_sel (w_sel),
      .i_in0 (result),
      .i_in1 (mem_rdata),
      .i_in2 (w_slt_data),
      .o_out (w_mux_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:    if (w_mem_accept) w_next_state = ST_MEM_REQ;
         ST_MEM_REQ: begin
            if (w_ack)          w_next_state = r_mem_we ? ST_IDLE : ST_WB;
            else if (w_timeout) w_next_state = ST_IDLE;
         end
         ST_WB:      w_next_state = ST_IDLE;
         default:    w_next_state = ST_IDLE;
      endcase
   end

   // Stall is gated by rst_n so it drops the instant reset asserts.
   always_comb begin
      stall   = rst_n && ((r_state != ST_IDLE) || w_mem_accept);
      mem_req = (r_state == ST_MEM_REQ);
      mem_we  = (r_state == ST_MEM_REQ) && r_mem_we;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rw        <= 1'b0;
         r_da        <= '0;
         r_reg_we    <= 1'b0;
         r_reg_addr  <= '0;
         r_reg_wdata <= '0;
         r_mem_err   <= 1'b0;
      end else begin
         r_reg_we  <= 1'b0;
         r_mem_err <= w_timeout;
         if (w_mem_accept) begin
            r_wait_cnt  <= '0;
            r_mem_we    <= MW;
            r_mem_addr  <= result;
            r_mem_wdata <= DData;
            r_rw        <= RW;
            r_da        <= DA;
         end else if ((r_state == ST_MEM_REQ) && !mem_ack) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         if (w_alu_accept) begin
            r_reg_we    <= RW && (DA != '0);
            r_reg_addr  <= DA;
            r_reg_wdata <= w_mux_out;
         end else if (w_ack && !r_mem_we) begin
            r_reg_we    <= r_rw && (r_da != '0);
            r_reg_addr  <= r_da;
            r_reg_wdata <= w_mux_out;
         end
      end
   end

   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign reg_we      = r_reg_we;
   assign reg_addr    = r_reg_addr;
   assign reg_wdata   = r_reg_wdata;
   assign mem_err     = r_mem_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage: a transaction-level model predicts
// every cycle's outputs, plus literal checks for the directed scenarios.
module tb_writeback_stage;

   localparam int TMO = 15;

   logic        clk;
   logic        rst_n;
   logic        valid_in;
   logic        RW;
   logic [4:0]  DA;
   logic [1:0]  MD;
   logic        MW;
   logic [31:0] result;
   logic        determinate;
   logic [31:0] DData;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        reg_we;
   logic [4:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic        mem_err;
   logic [1:0]  dbg_state;

   writeback_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_in    (valid_in),
      .RW          (RW),
      .DA          (DA),
      .MD          (MD),
      .MW          (MW),
      .result      (result),
      .determinate (determinate),
      .DData       (DData),
      .stall       (stall),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .reg_we      (reg_we),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata),
      .mem_err     (mem_err),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic        stall;
      logic        mem_req;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        reg_we;
      logic [4:0]  reg_addr;
      logic [31:0] reg_wdata;
      logic        mem_err;
   } exp_t;

   exp_t exp_q[$];

   int n_total = 0;
   int n_pass  = 0;

   // Registered outputs the model predicts for the coming cycle.
   logic        p_we   = 1'b0;
   logic [4:0]  p_addr = '0;
   logic [31:0] p_data = '0;
   logic        p_err  = 1'b0;

   // Event counters from an independent monitor, used by literal checks.
   int          n_req_cyc = 0;
   int          n_writes  = 0;
   int          n_errs    = 0;
   logic [31:0] last_wr_data  = '0;
   logic [31:0] last_mem_addr = '0;
   logic [31:0] last_mem_wd   = '0;
   logic        last_mem_we   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic void push_exp(logic s, logic mr, logic mw, logic [31:0] ma, logic [31:0] md);
      exp_t e;
      e.stall     = s;
      e.mem_req   = mr;
      e.mem_we    = mw;
      e.mem_addr  = ma;
      e.mem_wdata = md;
      e.reg_we    = p_we;
      e.reg_addr  = p_addr;
      e.reg_wdata = p_data;
      e.mem_err   = p_err;
      exp_q.push_back(e);
      p_we  = 1'b0;
      p_err = 1'b0;
   endfunction

   always @(negedge clk) begin
      if (rst_n && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("stall", stall, e.stall);
         chk("mem_req", mem_req, e.mem_req);
         chk("mem_err", mem_err, e.mem_err);
         chk("reg_we", reg_we, e.reg_we);
         if (e.mem_req) begin
            chk("mem_we", mem_we, e.mem_we);
            chk("mem_addr", mem_addr, e.mem_addr);
            chk("mem_wdata", mem_wdata, e.mem_wdata);
         end
         if (e.reg_we) begin
            chk("reg_addr", reg_addr, e.reg_addr);
            chk("reg_wdata", reg_wdata, e.reg_wdata);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_req) begin
            n_req_cyc++;
            last_mem_addr = mem_addr;
            last_mem_wd   = mem_wdata;
            last_mem_we   = mem_we;
         end
         if (reg_we) begin
            n_writes++;
            last_wr_data = reg_wdata;
         end
         if (mem_err) n_errs++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic junk_inputs;
      valid_in    = 1'($urandom);
      RW          = 1'($urandom);
      DA          = 5'($urandom);
      MD          = 2'($urandom);
      MW          = 1'($urandom);
      result      = $urandom;
      determinate = 1'($urandom);
      DData       = $urandom;
   endtask

   task automatic idle_cycle;
      junk_inputs();
      valid_in  = 1'b0;
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;
      push_exp(1'b0, 1'b0, 1'b0, '0, '0);
      tick();
   endtask

   task automatic do_alu(input logic [1:0] md, input logic rw, input logic [4:0] da,
                         input logic [31:0] res, input logic det);
      valid_in    = 1'b1;
      MD          = md;
      MW          = 1'b0;
      RW          = rw;
      DA          = da;
      result      = res;
      determinate = det;
      DData       = $urandom;
      mem_ack     = 1'($urandom);
      mem_rdata   = $urandom;
      push_exp(1'b0, 1'b0, 1'b0, '0, '0);
      p_we   = rw && (da != 5'd0);
      p_addr = da;
      p_data = (md == 2'd2) ? {31'd0, det} : res;
      tick();
   endtask

   // ack_at: index of the MEM_REQ cycle carrying the ack; >= TMO means none.
   task automatic do_mem(input logic mw, input logic [1:0] md, input logic rw, input logic [4:0] da,
                         input logic [31:0] res, input logic [31:0] dd, input logic [31:0] rdata,
                         input int ack_at);
      valid_in    = 1'b1;
      MW          = mw;
      MD          = md;
      RW          = rw;
      DA          = da;
      result      = res;
      DData       = dd;
      determinate = 1'($urandom);
      mem_ack     = 1'($urandom);
      mem_rdata   = $urandom;
      push_exp(1'b1, 1'b0, 1'b0, '0, '0);
      tick();
      for (int i = 0; i < TMO; i++) begin
         junk_inputs();
         mem_ack   = (i == ack_at);
         mem_rdata = (i == ack_at) ? rdata : $urandom;
         push_exp(1'b1, 1'b1, mw, res, dd);
         tick();
         if (i == ack_at) begin
            mem_ack = 1'b0;
            if (!mw) begin
               junk_inputs();
               p_we   = rw && (da != 5'd0);
               p_addr = da;
               p_data = rdata;
               push_exp(1'b1, 1'b0, 1'b0, '0, '0);
               tick();
            end
            return;
         end
      end
      mem_ack = 1'b0;
      p_err   = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   int          base_req;
   int          base_wr;
   int          base_err;
   logic [1:0]  alu_md_tab [3];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      alu_md_tab[0] = 2'd0;
      alu_md_tab[1] = 2'd2;
      alu_md_tab[2] = 2'd3;
      rst_n = 1'b0;
      valid_in = 1'b0; RW = 1'b0; DA = '0; MD = '0; MW = 1'b0;
      result = '0; determinate = 1'b0; DData = '0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_reg_we", reg_we, 1'b0);
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_stall", stall, 1'b0);
      chk("post_rst_mem_req", mem_req, 1'b0);
      chk("post_rst_mem_we", mem_we, 1'b0);
      chk("post_rst_reg_we", reg_we, 1'b0);
      chk("post_rst_mem_err", mem_err, 1'b0);
      chk("post_rst_mem_addr", mem_addr, 32'h0);
      chk("post_rst_reg_wdata", reg_wdata, 32'h0);

      // ALU write
      do_alu(2'd0, 1'b1, 5'd5, 32'h0000_1234, 1'b0);
      chk("lit_alu_we", reg_we, 1'b1);
      chk("lit_alu_addr", reg_addr, 32'd5);
      chk("lit_alu_data", reg_wdata, 32'h0000_1234);
      chk("lit_alu_stall", stall, 1'b0);

      // SLT write
      do_alu(2'd2, 1'b1, 5'd3, 32'hFFFF_FF00, 1'b1);
      chk("lit_slt_data", reg_wdata, 32'h0000_0001);

      // zero-register guard
      do_alu(2'd0, 1'b1, 5'd0, 32'hCAFE_0000, 1'b0);
      chk("lit_r0_we", reg_we, 1'b0);
      idle_cycle();

      // load, ack in the third request cycle
      base_req = n_req_cyc; base_wr = n_writes;
      do_mem(1'b0, 2'd1, 1'b1, 5'd7, 32'h40, 32'h1111, 32'hDEAD_BEEF, 2);
      chk("lit_ld_req_cycles", n_req_cyc - base_req, 32'd3);
      chk("lit_ld_addr", last_mem_addr, 32'h40);
      chk("lit_ld_writes", n_writes - base_wr, 32'd1);
      chk("lit_ld_data", last_wr_data, 32'hDEAD_BEEF);

      // store, ack in the first request cycle
      base_req = n_req_cyc; base_wr = n_writes;
      do_mem(1'b1, 2'd1, 1'b1, 5'd9, 32'h80, 32'h55, 32'h0BAD_0BAD, 0);
      idle_cycle();
      chk("lit_st_req_cycles", n_req_cyc - base_req, 32'd1);
      chk("lit_st_we", last_mem_we, 1'b1);
      chk("lit_st_wdata", last_mem_wd, 32'h55);
      chk("lit_st_writes", n_writes - base_wr, 32'd0);

      // timeout
      base_req = n_req_cyc; base_wr = n_writes; base_err = n_errs;
      do_mem(1'b0, 2'd1, 1'b1, 5'd4, 32'h100, 32'h0, 32'h0, TMO + 5);
      idle_cycle();
      idle_cycle();
      chk("lit_tmo_req_cycles", n_req_cyc - base_req, 32'd15);
      chk("lit_tmo_errs", n_errs - base_err, 32'd1);
      chk("lit_tmo_writes", n_writes - base_wr, 32'd0);

      // reset in the middle of a load
      base_wr = n_writes; base_err = n_errs;
      valid_in = 1'b1; MW = 1'b0; MD = 2'd1; RW = 1'b1; DA = 5'd6;
      result = 32'h200; DData = 32'h77; mem_ack = 1'b0;
      push_exp(1'b1, 1'b0, 1'b0, '0, '0);
      tick();
      push_exp(1'b1, 1'b1, 1'b0, 32'h200, 32'h77);
      tick();
      valid_in = 1'b1; MW = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_stall", stall, 1'b0);
      chk("mid_rst_mem_req", mem_req, 1'b0);
      chk("mid_rst_mem_we", mem_we, 1'b0);
      chk("mid_rst_mem_addr", mem_addr, 32'h0);
      chk("mid_rst_mem_wdata", mem_wdata, 32'h0);
      chk("mid_rst_reg_we", reg_we, 1'b0);
      chk("mid_rst_mem_err", mem_err, 1'b0);
      p_we = 1'b0; p_err = 1'b0;
      valid_in = 1'b0; mem_ack = 1'b1;
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      idle_cycle();
      idle_cycle();
      chk("rst_abandon_writes", n_writes - base_wr, 32'd0);
      chk("rst_abandon_errs", n_errs - base_err, 32'd0);

      // randomized traffic
      for (int t = 0; t < 150; t++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind < 2) begin
            idle_cycle();
         end else if (kind < 6) begin
            do_alu(alu_md_tab[$urandom_range(0, 2)], 1'($urandom),
                   ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                   $urandom, 1'($urandom));
         end else if (kind < 8) begin
            do_mem(1'b0, 2'd1, 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(0, TMO + 3));
         end else begin
            do_mem(1'b1, 2'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(0, TMO + 3));
         end
      end
      idle_cycle();
      idle_cycle();
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
